pipe_trace_monitor: RTL and testbench

Synthesizable, parametrised trace and hazard-statistics unit attached to the 5-stage RISC-V pipeline core, alongside the datapath/controller/hazard unit. Captures retired instructions (PC, instruction word) into a circular buffer under a trigger/post-trigger state machine. Counts cycles, retirements, stalls, flushes and forwards. Provides on-chip what the simulation trace printout provides off-chip.

---
 rtl/pipe_trace_pkg.sv | 21 ++
 rtl/trace_ram.sv | 37 +++
 rtl/pipe_trace_monitor.sv | 190 +++++++++++++++++++
 tb/tb_pipe_trace_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace monitor: FSM encoding and event-counter slots.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    // Slot of each event in the counter bank / event vector.
    localparam int EV_CYCLE  = 0;
    localparam int EV_RETIRE = 1;
    localparam int EV_STALL  = 2;
    localparam int EV_FLUSH  = 3;
    localparam int EV_FWD    = 4;
    localparam int NUM_EV    = 5;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x WIDTH array, one write port, one registered read port.
// Latency: read data appears one cycle after rdEn; a same-cycle write is not bypassed.
// Backpressure: none; every write and read request is accepted.
// Ports: clk/reset, wrEn/wrAddr/wrData write port, rdEn/rdAddr request, rdData registered output (holds between reads).
module trace_ram #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage itself is not reset; stale entries are hidden by the owner's entry count.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/pipe_trace_monitor.sv
// Trace capture of retired instructions with PC trigger / post-trigger FSM, plus hazard event counters.
// Latency: captures on the WB edge; read data valid one cycle after RdReq.
// Backpressure: none; passive observer of the pipeline, never stalls it.
// Ports: pipeline taps (RetireW, PCW, InstrW, Stall*/Flush*/Forward*), control (Arm, Stop, TrigEn, TrigPC, PostCnt),
//        read port (RdReq, RdIdx -> RdValid, RdPC, RdInstr), status (State, Done, Count, Wrapped, *Cnt).
module pipe_trace_monitor
    import pipe_trace_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int DEPTH  = 16,
    parameter  int CNT_W  = 32,
    parameter  int POST_W = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RetireW,
    input  logic [XLEN-1:0]   PCW,
    input  logic [31:0]       InstrW,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic              Arm,
    input  logic              Stop,
    input  logic              TrigEn,
    input  logic [XLEN-1:0]   TrigPC,
    input  logic [POST_W-1:0] PostCnt,
    input  logic              RdReq,
    input  logic [AW-1:0]     RdIdx,
    output logic              RdValid,
    output logic [XLEN-1:0]   RdPC,
    output logic [31:0]       RdInstr,
    output logic [1:0]        State,
    output logic              Done,
    output logic [AW:0]       Count,
    output logic              Wrapped,
    output logic [CNT_W-1:0]  CycleCnt,
    output logic [CNT_W-1:0]  RetireCnt,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt,
    output logic [CNT_W-1:0]  FwdCnt
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    trace_state_t      state, nextState;
    logic              capturing;
    logic              wrEn;
    logic              trigHit;
    logic [AW-1:0]     wptr;
    logic [POST_W-1:0] postLeft;
    logic [NUM_EV-1:0] ev;
    logic [CNT_W-1:0]  evCnt [NUM_EV];

    logic [AW-1:0]     rdAddr;
    logic              rdHit;
    logic              rdHitQ;
    logic [XLEN+31:0]  rdData;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nextState = state;
        if (Arm) begin
            nextState = ST_ARMED;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (trigHit) begin
                        nextState = (Stop || PostCnt == '0) ? ST_DONE : ST_POST;
                    end else if (Stop) begin
                        nextState = ST_DONE;
                    end
                end
                ST_POST: begin
                    // The write that consumes the last post-trigger slot ends capture.
                    if (Stop || (RetireW && postLeft == POST_W'(1))) begin
                        nextState = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        State     = state;
        Done      = (state == ST_DONE);
        // Arm clears everything that cycle, so nothing is captured or counted.
        capturing = (state == ST_ARMED || state == ST_POST) && !Arm;
        wrEn      = capturing && RetireW;
        trigHit   = (state == ST_ARMED) && RetireW && TrigEn && (PCW == TrigPC);
    end

    // ---------------- event vector ----------------
    always_comb begin
        ev            = '0;
        ev[EV_CYCLE]  = 1'b1;
        ev[EV_RETIRE] = RetireW;
        ev[EV_STALL]  = StallF | StallD;
        ev[EV_FLUSH]  = FlushD | FlushE;
        ev[EV_FWD]    = (ForwardAE != 2'b00) | (ForwardBE != 2'b00);
    end

    // ---------------- pointers, post counter, event counters ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            Count    <= '0;
            Wrapped  <= 1'b0;
            postLeft <= '0;
            for (int i = 0; i < NUM_EV; i++) evCnt[i] <= '0;
        end else if (Arm) begin
            wptr     <= '0;
            Count    <= '0;
            Wrapped  <= 1'b0;
            postLeft <= '0;
            for (int i = 0; i < NUM_EV; i++) evCnt[i] <= '0;
        end else if (capturing) begin
            if (wrEn) begin
                wptr <= wptr + AW'(1);
                if (Count == FULL) begin
                    Wrapped <= 1'b1;
                end else begin
                    Count <= Count + (AW+1)'(1);
                end
            end
            if (trigHit) begin
                postLeft <= PostCnt;
            end else if (state == ST_POST && RetireW) begin
                postLeft <= postLeft - POST_W'(1);
            end
            for (int i = 0; i < NUM_EV; i++) begin
                if (ev[i] && !(&evCnt[i])) evCnt[i] <= evCnt[i] + CNT_W'(1);
            end
        end
    end

    assign CycleCnt  = evCnt[EV_CYCLE];
    assign RetireCnt = evCnt[EV_RETIRE];
    assign StallCnt  = evCnt[EV_STALL];
    assign FlushCnt  = evCnt[EV_FLUSH];
    assign FwdCnt    = evCnt[EV_FWD];

    // ---------------- read path ----------------
    // Oldest entry sits Count slots behind the write pointer; when full, Count's low bits are 0.
    assign rdAddr = wptr - Count[AW-1:0] + RdIdx;
    assign rdHit  = ({1'b0, RdIdx} < Count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RdValid <= 1'b0;
            rdHitQ  <= 1'b0;
        end else begin
            RdValid <= RdReq;
            if (RdReq) rdHitQ <= rdHit;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + 32)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (wrEn),
        .wrAddr (wptr),
        .wrData ({PCW, InstrW}),
        .rdEn   (RdReq),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    // Out-of-range reads return zero; both the RAM register and rdHitQ hold between reads.
    assign RdPC    = rdHitQ ? rdData[XLEN+31:32] : '0;
    assign RdInstr = rdHitQ ? rdData[31:0]       : '0;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed bench for pipe_trace_monitor: capture, wrap, trigger/post, counters, async reset, Arm priority.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pipe_trace_monitor;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 32;
    localparam int POST_W = 8;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              RetireW;
    logic [XLEN-1:0]   PCW;
    logic [31:0]       InstrW;
    logic              StallF, StallD, FlushD, FlushE;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              Arm, Stop, TrigEn;
    logic [XLEN-1:0]   TrigPC;
    logic [POST_W-1:0] PostCnt;
    logic              RdReq;
    logic [AW-1:0]     RdIdx;
    logic              RdValid;
    logic [XLEN-1:0]   RdPC;
    logic [31:0]       RdInstr;
    logic [1:0]        State;
    logic              Done;
    logic [AW:0]       Count;
    logic              Wrapped;
    logic [CNT_W-1:0]  CycleCnt, RetireCnt, StallCnt, FlushCnt, FwdCnt;

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    pipe_trace_monitor #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .POST_W(POST_W)
    ) dut (
        .clk(clk), .reset(reset),
        .RetireW(RetireW), .PCW(PCW), .InstrW(InstrW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Arm(Arm), .Stop(Stop), .TrigEn(TrigEn), .TrigPC(TrigPC), .PostCnt(PostCnt),
        .RdReq(RdReq), .RdIdx(RdIdx),
        .RdValid(RdValid), .RdPC(RdPC), .RdInstr(RdInstr),
        .State(State), .Done(Done), .Count(Count), .Wrapped(Wrapped),
        .CycleCnt(CycleCnt), .RetireCnt(RetireCnt), .StallCnt(StallCnt),
        .FlushCnt(FlushCnt), .FwdCnt(FwdCnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc);
        RetireW = 1'b1;
        PCW     = pc;
        InstrW  = ~pc;
        step();
        RetireW = 1'b0;
    endtask

    task automatic doStop();
        Stop = 1'b1;
        step();
        Stop = 1'b0;
    endtask

    task automatic doArm();
        Arm = 1'b1;
        step();
        Arm = 1'b0;
    endtask

    task automatic rdChk(input string tag, input int idx, input logic [31:0] expPC, input logic [31:0] expInstr);
        RdReq = 1'b1;
        RdIdx = AW'(idx);
        step();
        RdReq = 1'b0;
        chk({tag, ".valid"}, 64'(RdValid), 64'd1);
        chk({tag, ".pc"},    64'(RdPC),    64'(expPC));
        chk({tag, ".instr"}, 64'(RdInstr), 64'(expInstr));
    endtask

    initial begin
        reset = 1'b1;
        RetireW = 1'b0; PCW = '0; InstrW = '0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        Arm = 1'b0; Stop = 1'b0; TrigEn = 1'b0; TrigPC = '0; PostCnt = '0;
        RdReq = 1'b0; RdIdx = '0;

        // ---- reset state ----
        step(); step();
        chk("rst.state",   64'(State),    64'd0);
        chk("rst.done",    64'(Done),     64'd0);
        chk("rst.count",   64'(Count),    64'd0);
        chk("rst.wrapped", 64'(Wrapped),  64'd0);
        chk("rst.cycle",   64'(CycleCnt), 64'd0);
        chk("rst.rdvalid", 64'(RdValid),  64'd0);
        reset = 1'b0;
        step();
        chk("idle.ignore", 64'(CycleCnt), 64'd0);

        // ---- 1: free-running capture, 5 retires, Stop ----
        doArm();
        chk("t1.armed", 64'(State), 64'd1);
        chk("t1.count0", 64'(Count), 64'd0);
        for (int i = 0; i < 5; i++) retire(32'(i * 4));
        doStop();
        chk("t1.state",   64'(State),     64'd3);
        chk("t1.done",    64'(Done),      64'd1);
        chk("t1.count",   64'(Count),     64'd5);
        chk("t1.wrapped", 64'(Wrapped),   64'd0);
        chk("t1.retire",  64'(RetireCnt), 64'd5);
        chk("t1.cycle",   64'(CycleCnt),  64'd6);
        for (int i = 0; i < 5; i++) rdChk($sformatf("t1.rd%0d", i), i, 32'(i * 4), ~32'(i * 4));
        step();
        chk("t1.rdvalid_drop", 64'(RdValid), 64'd0);
        chk("t1.rd_hold",      64'(RdPC),    64'h10);
        rdChk("t1.rd_oob", 5, 32'h0, 32'h0);
        retire(32'h80);
        chk("t1.frozen_count", 64'(Count),    64'd5);
        chk("t1.frozen_cycle", 64'(CycleCnt), 64'd6);

        // ---- 6: Arm + Stop in DONE -> Arm wins ----
        Arm = 1'b1; Stop = 1'b1;
        step();
        Arm = 1'b0; Stop = 1'b0;
        chk("t6.state",  64'(State),     64'd1);
        chk("t6.count",  64'(Count),     64'd0);
        chk("t6.cycle",  64'(CycleCnt),  64'd0);
        chk("t6.retire", 64'(RetireCnt), 64'd0);

        // ---- 2: wrap with 20 retires ----
        for (int i = 0; i < 20; i++) begin
            retire(32'h100 + 32'(i * 4));
            if (i == 15) begin
                chk("t2.full_count",   64'(Count),   64'd16);
                chk("t2.full_nowrap",  64'(Wrapped), 64'd0);
            end
        end
        doStop();
        chk("t2.count",   64'(Count),   64'd16);
        chk("t2.wrapped", 64'(Wrapped), 64'd1);
        rdChk("t2.rd0",  0,  32'h110, ~32'h110);
        rdChk("t2.rd15", 15, 32'h14C, ~32'h14C);

        // ---- 3: PC trigger with 3 post entries ----
        doArm();
        TrigEn = 1'b1; TrigPC = 32'h20; PostCnt = 8'd3;
        for (int i = 0; i <= 16; i++) begin
            retire(32'(i * 4));
            if (i == 7)  chk("t3.pre",  64'(State), 64'd1);
            if (i == 8)  chk("t3.post", 64'(State), 64'd2);
            if (i == 10) chk("t3.post_last", 64'(State), 64'd2);
            if (i == 11) chk("t3.done", 64'(State), 64'd3);
        end
        chk("t3.count",  64'(Count),     64'd12);
        chk("t3.retire", 64'(RetireCnt), 64'd12);
        rdChk("t3.newest", 11, 32'h2C, ~32'h2C);
        TrigEn = 1'b0;

        // ---- 4: hazard counters over 10 ARMED cycles ----
        doArm();
        for (int c = 0; c < 10; c++) begin
            StallF    = (c == 1 || c == 4);
            StallD    = (c == 4);
            FlushE    = (c == 6);
            ForwardAE = (c == 8) ? 2'd2 : 2'd0;
            ForwardBE = (c == 8) ? 2'd1 : 2'd0;
            Stop      = (c == 9);
            step();
        end
        StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0;
        ForwardAE = 2'd0; ForwardBE = 2'd0; Stop = 1'b0;
        chk("t4.state",  64'(State),     64'd3);
        chk("t4.cycle",  64'(CycleCnt),  64'd10);
        chk("t4.stall",  64'(StallCnt),  64'd2);
        chk("t4.flush",  64'(FlushCnt),  64'd1);
        chk("t4.fwd",    64'(FwdCnt),    64'd1);
        chk("t4.retire", 64'(RetireCnt), 64'd0);

        // ---- 5: asynchronous reset during POST ----
        doArm();
        TrigEn = 1'b1; TrigPC = 32'h18; PostCnt = 8'd5;
        for (int i = 0; i < 7; i++) retire(32'(i * 4));
        chk("t5.post",  64'(State), 64'd2);
        chk("t5.count", 64'(Count), 64'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("t5.rst_state", 64'(State),    64'd0);
        chk("t5.rst_count", 64'(Count),    64'd0);
        chk("t5.rst_cycle", 64'(CycleCnt), 64'd0);
        chk("t5.rst_rdpc",  64'(RdPC),     64'd0);
        step();
        reset = 1'b0;
        TrigEn = 1'b0;
        step();
        doArm();
        chk("t5.rearm", 64'(State), 64'd1);
        retire(32'h200);
        doStop();
        chk("t5.newcount", 64'(Count), 64'd1);
        rdChk("t5.rd0", 0, 32'h200, ~32'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
